// File: rtl/virtual_input_ctrl_if.sv
// Command channel of the virtual input controller: one valid/ready
// handshake carrying a channel selector and a 2-bit operation code.
interface virtual_input_ctrl_if #(
  parameter int SEL_W = 5
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [SEL_W-1:0] cmd_sel;
  logic [1:0]       cmd_op;

  // Command source: drives the command, observes ready.
  modport master (
    output cmd_valid,
    output cmd_sel,
    output cmd_op,
    input  cmd_ready
  );

  // Controller side: consumes the command, drives ready.
  modport slave (
    input  cmd_valid,
    input  cmd_sel,
    input  cmd_op,
    output cmd_ready
  );

endinterface

// File: rtl/virtual_input_ctrl.sv
// Virtual input controller: a register bank of virtual push-buttons and
// slide switches updated by valid/ready commands (toggle, set, clear,
// timed press, clear-all).
// Optional build macro VIRTUAL_INPUT_KEY_ACTIVE_LOW_EN: drive buttons
// active-low (released = 1) to match the DE2-115 KEY pins. Switch
// polarity, FSM, handshake and timing are identical in both builds.
module virtual_input_ctrl #(
  parameter int NUM_BUTTONS  = 4,
  parameter int NUM_SWITCHES = 18,
  parameter int SEL_W        = 5,
  parameter int PULSE_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  virtual_input_ctrl_if.slave     cmd,
  output logic [NUM_BUTTONS-1:0]  buttons,
  output logic [NUM_SWITCHES-1:0] switches,
  output logic                    busy
);

  localparam int NUM_CH = NUM_BUTTONS + NUM_SWITCHES;
  localparam int CNT_W  = $clog2(PULSE_CYCLES + 1);
  localparam int BIDX_W = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;
  localparam int SIDX_W = (NUM_SWITCHES > 1) ? $clog2(NUM_SWITCHES) : 1;

`ifdef VIRTUAL_INPUT_KEY_ACTIVE_LOW_EN
  localparam logic BTN_REL = 1'b1;
`else
  localparam logic BTN_REL = 1'b0;
`endif

  typedef enum logic [1:0] {
    OP_TOGGLE = 2'b00,
    OP_SET    = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_PULSE  = 2'b11
  } op_t;

  typedef enum logic {
    IDLE  = 1'b0,
    PRESS = 1'b1
  } state_t;

  // Elaboration-time sanity check on the channel map: at least one
  // selector code must be left over for clear-all.
  if (NUM_BUTTONS < 1 || NUM_BUTTONS > 8 || NUM_SWITCHES < 1 ||
      NUM_SWITCHES > 32 || NUM_CH > (2**SEL_W) - 1 || PULSE_CYCLES < 1) begin : g_bad_cfg
    $error("virtual_input_ctrl: illegal parameter combination");
  end

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIDX_W-1:0]   press_idx_q, press_idx_d;
  // Button levels are kept as "asserted = 1" internally; polarity is
  // applied only at the output so the update logic is build-independent.
  logic [NUM_BUTTONS-1:0]  btn_q, btn_d;
  logic [NUM_SWITCHES-1:0] sw_q, sw_d;

  logic [SEL_W-1:0]  sel;
  op_t               op;
  logic [BIDX_W-1:0] btn_idx;
  logic [SIDX_W-1:0] sw_idx;
  logic              sel_is_btn;
  logic              sel_is_sw;

  assign sel = cmd.cmd_sel;
  assign op  = op_t'(cmd.cmd_op);

  // Legacy ordering: selector 0 is the most significant button, the first
  // switch selector is the most significant switch. Indices are only
  // meaningful when the matching sel_is_* flag is set.
  assign sel_is_btn = int'(sel) < NUM_BUTTONS;
  assign sel_is_sw  = !sel_is_btn && (int'(sel) < NUM_CH);
  assign btn_idx    = BIDX_W'(NUM_BUTTONS - 1 - int'(sel));
  assign sw_idx     = SIDX_W'(NUM_SWITCHES - 1 - (int'(sel) - NUM_BUTTONS));

  // Next-state and register-bank update for the IDLE/PRESS controller.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path through
    // the case/if tree leaves one unassigned, which would infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    press_idx_d = press_idx_q;
    btn_d       = btn_q;
    sw_d        = sw_q;

    case (state_q)
      IDLE: begin
        if (cmd.cmd_valid) begin
          if (sel_is_btn) begin
            case (op)
              OP_TOGGLE: btn_d[btn_idx] = ~btn_q[btn_idx];
              OP_SET:    btn_d[btn_idx] = 1'b1;
              OP_CLEAR:  btn_d[btn_idx] = 1'b0;
              OP_PULSE: begin
                // A press on an already latched button still runs and
                // releases the button when it ends.
                btn_d[btn_idx] = 1'b1;
                press_idx_d    = btn_idx;
                cnt_d          = CNT_W'(PULSE_CYCLES - 1);
                state_d        = PRESS;
              end
              default: btn_d = btn_q;
            endcase
          end else if (sel_is_sw) begin
            case (op)
              OP_SET:   sw_d[sw_idx] = 1'b1;
              OP_CLEAR: sw_d[sw_idx] = 1'b0;
              default:  sw_d[sw_idx] = ~sw_q[sw_idx];  // TOGGLE and PULSE
            endcase
          end else begin
            // Spare selector codes release everything; op is ignored.
            btn_d = '0;
            sw_d  = '0;
          end
        end
      end

      PRESS: begin
        if (cnt_q == '0) begin
          btn_d[press_idx_q] = 1'b0;
          state_d            = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and register bank, synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      press_idx_q <= '0;
      btn_q       <= '0;
      sw_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      press_idx_q <= press_idx_d;
      btn_q       <= btn_d;
      sw_q        <= sw_d;
    end
  end

  // Outputs come straight from registers; ready depends only on state.
  assign cmd.cmd_ready = (state_q == IDLE);
  assign busy          = (state_q == PRESS);
  assign buttons       = btn_q ^ {NUM_BUTTONS{BTN_REL}};
  assign switches      = sw_q;

endmodule

// File: doc/virtual_input_ctrl.md
# virtual_input_ctrl

Clocked, parametrised virtual-input controller for the DE2-115 virtual input path. It accepts one command per valid/ready handshake and holds a register bank of virtual push-buttons and slide switches that stands in for the board's KEY and SW pins. It extends the fixed 22-channel toggle decoder with:
- configurable channel counts;
- explicit set, clear and toggle operations;
- timed momentary button presses;
- a clear-all code.

## Interface
Parameters:
- NUM_BUTTONS, 4, number of virtual buttons (1..8)
- NUM_SWITCHES, 18, number of virtual switches (1..32)
- SEL_W, 5, selector width. Must satisfy NUM_BUTTONS+NUM_SWITCHES <= 2**SEL_W-1, so at least one clear-all code exists.
- PULSE_CYCLES, 1000, length of a momentary press in clk cycles (>=1)

Ports:
- clk  in  1  single clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_sel  in  SEL_W  channel selector
- cmd_op  in  2  operation: 00 TOGGLE, 01 SET, 10 CLEAR, 11 PULSE
- buttons  out  NUM_BUTTONS  registered virtual button levels
- switches  out  NUM_SWITCHES  registered virtual switch levels
- busy  out  1  a timed press is in progress

## Operation
- A command is accepted on a rising edge where cmd_valid and cmd_ready are both high. cmd_sel and cmd_op are sampled only on that edge.
- Channel map (keeps the legacy ordering):
  - sel 0..NUM_BUTTONS-1 -> buttons[NUM_BUTTONS-1-sel]
  - sel NUM_BUTTONS..NUM_BUTTONS+NUM_SWITCHES-1 -> switches[NUM_SWITCHES-1-(sel-NUM_BUTTONS)]
  - any sel >= NUM_BUTTONS+NUM_SWITCHES -> CLEAR-ALL: every button and switch is released. cmd_op is ignored.
- Switch channel ops:
  - TOGGLE and PULSE invert the bit.
  - SET forces the bit to asserted; CLEAR forces it to released.
- Button channel ops:
  - SET latches the button asserted (held press).
  - CLEAR releases the button.
  - TOGGLE inverts the latched level.
  - PULSE starts a timed press.
- FSM states:
  - IDLE: cmd_ready=1, busy=0. All ops except a button PULSE complete in one cycle and stay in IDLE. A button PULSE asserts the bit, loads the counter with PULSE_CYCLES-1 and moves to PRESS.
  - PRESS: cmd_ready=0, busy=1. The counter decrements every cycle. When the counter is 0, the button is released and the FSM returns to IDLE.
- PULSE on a button that is already latched asserted: the press still runs and the button is released at the end of it.
- Only the addressed bit changes; all other outputs hold.
- Counter width is $clog2(PULSE_CYCLES+1). The counter never wraps below 0.

## Timing
- Reset values (reset high on an edge): buttons all released, switches 0, cmd_ready 1, busy 0, FSM IDLE, counter 0.
- Single-cycle op accepted at edge N: the output changes after edge N, and a new command can be accepted at edge N+1. Sustained throughput is one command per clk.
- Button PULSE accepted at edge N:
  - button asserted from edge N through edge N+PULSE_CYCLES, i.e. exactly PULSE_CYCLES cycles;
  - cmd_ready low for the same window;
  - button released and cmd_ready high after edge N+PULSE_CYCLES.
- PULSE_CYCLES=1: asserted for one cycle, with one cycle in PRESS.
- cmd_valid during PRESS: the command is not accepted. The source must hold cmd_valid and the command fields stable until cmd_ready is high.
- Reset mid-press takes priority: all outputs reach their reset values after that edge and the press is aborted.
- reset and cmd_valid on the same edge: reset wins and the command is dropped.
- There is no combinational path from cmd_* to any output. cmd_ready depends only on the FSM state.

## Configuration
- Macro: VIRTUAL_INPUT_KEY_ACTIVE_LOW_EN
- Defined: buttons are driven active-low to match the DE2-115 KEY pins. Released = 1 and asserted = 0, so the reset value of buttons is all ones. Switch polarity is unchanged.
- Undefined: buttons are active-high. Released = 0 and the reset value is all zeros.
- The FSM, handshake and timing are identical in both builds. Only the button output polarity differs.

## Test plan
All cases use defaults, with PULSE_CYCLES=4 where a press is involved.
- Reset then idle: hold reset for 2 cycles -> buttons=4'h0 (4'hF with the macro), switches=0, cmd_ready=1, busy=0.
- Switch ops: sel=4 TOGGLE, then sel=4 SET, then sel=21 SET, then sel=4 CLEAR on back-to-back cycles -> switches[17] goes 1,1, switches[0]=1, switches[17]=0. cmd_ready stays 1 throughout.
- Timed press: sel=0 PULSE at edge N -> buttons[3] asserted for exactly 4 cycles. cmd_ready=0 and busy=1 for the same window. A sel=1 SET held valid during PRESS is accepted at edge N+5, setting buttons[2].
- Clear-all: set sel=2, 5 and 21, then issue sel=31 (op=TOGGLE) -> all buttons released and switches=0 after one cycle.
- Reset mid-press: sel=3 PULSE, reset asserted 2 cycles later -> after that edge buttons[0] released, busy=0, cmd_ready=1. The press does not resume after reset is released.
- Button latch vs pulse: sel=1 SET, then sel=1 PULSE -> buttons[2] stays asserted for 4 cycles, then is released.
